// File: rtl/wb_collector.sv
// Writeback collector: per-port FIFOs for the FU writeback ports, round-robin serialised onto one
// valid/ready scoreboard port. Optional same-cycle bypass when WB_COLLECTOR_BYPASS_EN is defined.
module wb_collector #(
    parameter int unsigned NR_WB_PORTS   = 5,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
    input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_i,
    input  logic [NR_WB_PORTS*64-1:0]              wb_data_i,
    input  logic [NR_WB_PORTS-1:0]                 wb_ex_valid_i,
    input  logic [NR_WB_PORTS*64-1:0]              wb_ex_cause_i,
    output logic                                   sb_valid_o,
    input  logic                                   sb_ready_i,
    output logic [TRANS_ID_BITS-1:0]               sb_trans_id_o,
    output logic [63:0]                            sb_data_o,
    output logic                                   sb_ex_valid_o,
    output logic [63:0]                            sb_ex_cause_o,
    output logic                                   overflow_o,
    output logic [$clog2(NR_WB_PORTS)-1:0]         overflow_port_o
);

    localparam int unsigned PortW = $clog2(NR_WB_PORTS);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              data;
        logic                     ex_valid;
        logic [63:0]              ex_cause;
    } entry_t;

    entry_t           mem_q    [NR_WB_PORTS][FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q [NR_WB_PORTS];
    logic [PtrW-1:0]  rd_ptr_q [NR_WB_PORTS];
    logic [CntW-1:0]  cnt_q    [NR_WB_PORTS];

    entry_t           in_entry [NR_WB_PORTS];
    entry_t           out_entry;
    logic [NR_WB_PORTS-1:0] not_empty, full, push, pop, drop;
    logic             any_buf, bypass, handshake;
    logic [PortW-1:0] grant;
    logic [PortW-1:0] rr_q, rr_d;
    logic             lock_q, lock_d;
    logic [PortW-1:0] lock_port_q, lock_port_d;
    logic             overflow_q, overflow_d;
    logic [PortW-1:0] overflow_port_q, overflow_port_d;

    // First requester at or after start, wrapping modulo NR_WB_PORTS.
    function automatic logic [PortW-1:0] rr_pick(input logic [NR_WB_PORTS-1:0] req,
                                                 input logic [PortW-1:0]       start);
        logic [PortW-1:0] pick;
        logic             found;
        int               idx;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < int'(NR_WB_PORTS); i++) begin
            idx = (int'(start) + i) % int'(NR_WB_PORTS);
            if (!found && req[idx]) begin
                pick  = PortW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
            in_entry[p].trans_id = wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS];
            in_entry[p].data     = wb_data_i[p*64 +: 64];
            in_entry[p].ex_valid = wb_ex_valid_i[p];
            in_entry[p].ex_cause = wb_ex_cause_i[p*64 +: 64];
            not_empty[p]         = (cnt_q[p] != '0);
            full[p]              = (cnt_q[p] == CntW'(FIFO_DEPTH));
        end
    end

    always_comb begin
        any_buf = |not_empty;
`ifdef WB_COLLECTOR_BYPASS_EN
        bypass  = !any_buf && !flush_i && (|wb_valid_i);
`else
        bypass  = 1'b0;
`endif
        // A presented entry keeps its grant until accepted, regardless of new arrivals.
        if (lock_q) begin
            grant = lock_port_q;
        end else if (any_buf) begin
            grant = rr_pick(not_empty, rr_q);
        end else begin
            grant = rr_pick(wb_valid_i, rr_q);
        end

        sb_valid_o = lock_q || any_buf || bypass;
        out_entry  = bypass ? in_entry[grant] : mem_q[grant][rd_ptr_q[grant]];
        handshake  = sb_valid_o && sb_ready_i && !flush_i;

        for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
            pop[p]  = handshake && !bypass && (grant == PortW'(p));
            push[p] = wb_valid_i[p] && !flush_i && (!full[p] || pop[p])
                      && !(bypass && sb_ready_i && (grant == PortW'(p)));
            drop[p] = wb_valid_i[p] && !flush_i && full[p] && !pop[p];
        end

        lock_d      = sb_valid_o && !sb_ready_i && !flush_i;
        lock_port_d = grant;
        rr_d        = rr_q;
        if (handshake) begin
            rr_d = (grant == PortW'(NR_WB_PORTS - 1)) ? '0 : grant + 1'b1;
        end

        overflow_d      = |drop;
        overflow_port_d = '0;
        for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
            if (drop[p]) overflow_port_d = PortW'(p);
        end
    end

    assign sb_trans_id_o   = out_entry.trans_id;
    assign sb_data_o       = out_entry.data;
    assign sb_ex_valid_o   = out_entry.ex_valid;
    assign sb_ex_cause_o   = out_entry.ex_cause;
    assign overflow_o      = overflow_q;
    assign overflow_port_o = overflow_port_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q            <= '0;
            lock_q          <= 1'b0;
            lock_port_q     <= '0;
            overflow_q      <= 1'b0;
            overflow_port_q <= '0;
        end else begin
            rr_q            <= rr_d;
            lock_q          <= lock_d;
            lock_port_q     <= lock_port_d;
            overflow_q      <= overflow_d;
            overflow_port_q <= overflow_port_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
            if (rst_i || flush_i) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
            end else begin
                if (push[p]) begin
                    wr_ptr_q[p] <= (wr_ptr_q[p] == PtrW'(FIFO_DEPTH - 1)) ? '0
                                                                          : wr_ptr_q[p] + 1'b1;
                end
                if (pop[p]) begin
                    rd_ptr_q[p] <= (rd_ptr_q[p] == PtrW'(FIFO_DEPTH - 1)) ? '0
                                                                          : rd_ptr_q[p] + 1'b1;
                end
                if (push[p] && !pop[p]) begin
                    cnt_q[p] <= cnt_q[p] + CntW'(1);
                end else if (!push[p] && pop[p]) begin
                    cnt_q[p] <= cnt_q[p] - CntW'(1);
                end
            end
        end
    end

    // Storage needs no reset: occupancy is tracked solely by cnt_q.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
            if (push[p]) mem_q[p][wr_ptr_q[p]] <= in_entry[p];
        end
    end

endmodule
